// File: rtl/ram_burst_pkg.sv
// Shared command encoding for the ram_burst command-driven RAM.
// Imported by ram_burst and ram_burst_ptr.
package ram_burst_pkg;

   localparam int CMD_W = 2;

   typedef enum logic [CMD_W-1:0] {
      CMD_WR_ADDR = 2'b00,
      CMD_WR_DATA = 2'b01,
      CMD_RD_ADDR = 2'b10,
      CMD_RD_DATA = 2'b11
   } cmd_e;

endpackage

// File: rtl/ram_burst_ptr.sv
// Address pointer with sync reset, range-checked load and wrap-around increment.
// Ports: clk, rst, load, inc, addr -> ptr, illegal (load of addr >= MEM_DEPTH).
module ram_burst_ptr #(
   parameter int ADDR_SIZE = 8,
   parameter int MEM_DEPTH = 256
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic                 inc,
   input  logic [ADDR_SIZE-1:0] addr,
   output logic [ADDR_SIZE-1:0] ptr,
   output logic                 illegal
);

   // One extra bit so MEM_DEPTH == 2**ADDR_SIZE is representable.
   localparam logic [ADDR_SIZE:0]   DEPTH_C = (ADDR_SIZE+1)'(MEM_DEPTH);
   localparam logic [ADDR_SIZE-1:0] LAST_C  = ADDR_SIZE'(MEM_DEPTH - 1);

   assign illegal = load && ({1'b0, addr} >= DEPTH_C);

   // An illegal load leaves the pointer untouched.
   always_ff @(posedge clk) begin
      if (rst)
         ptr <= '0;
      else if (load && !illegal)
         ptr <= addr;
      else if (inc)
         ptr <= (ptr == LAST_C) ? '0 : ptr + ADDR_SIZE'(1);
   end

endmodule

// File: rtl/ram_burst.sv
// Command-driven single-port RAM with independent read/write pointers.
// Ports: clk, rst, din (cmd+payload), rx_valid -> dout, tx_valid, err (sticky).
// RAM_BURST_AUTO_INC_EN: pointers advance after each data command.
module ram_burst
   import ram_burst_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_SIZE  = 8,
   parameter int MEM_DEPTH  = 256
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DATA_WIDTH+CMD_W-1:0] din,
   input  logic                        rx_valid,
   output logic [DATA_WIDTH-1:0]       dout,
   output logic                        tx_valid,
   output logic                        err
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

   cmd_e                  cmd;
   logic [DATA_WIDTH-1:0] payload;
   logic [ADDR_SIZE-1:0]  addr;
   logic                  wr_load, wr_data, rd_load, rd_data;
   logic                  wr_inc, rd_inc;
   logic [ADDR_SIZE-1:0]  wr_ptr, rd_ptr;
   logic                  wr_ill, rd_ill;
   logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

   assign cmd     = cmd_e'(din[DATA_WIDTH+CMD_W-1:DATA_WIDTH]);
   assign payload = din[DATA_WIDTH-1:0];
   assign addr    = din[ADDR_SIZE-1:0];

   always_comb begin
      wr_load = 1'b0;
      wr_data = 1'b0;
      rd_load = 1'b0;
      rd_data = 1'b0;
      if (rx_valid) begin
         unique case (cmd)
            CMD_WR_ADDR: wr_load = 1'b1;
            CMD_WR_DATA: wr_data = 1'b1;
            CMD_RD_ADDR: rd_load = 1'b1;
            CMD_RD_DATA: rd_data = 1'b1;
         endcase
      end
   end

`ifdef RAM_BURST_AUTO_INC_EN
   assign wr_inc = wr_data;
   assign rd_inc = rd_data;
`else
   assign wr_inc = 1'b0;
   assign rd_inc = 1'b0;
`endif

   ram_burst_ptr #(.ADDR_SIZE(ADDR_SIZE), .MEM_DEPTH(MEM_DEPTH)) u_wr (
      .clk     (clk),
      .rst     (rst),
      .load    (wr_load),
      .inc     (wr_inc),
      .addr    (addr),
      .ptr     (wr_ptr),
      .illegal (wr_ill)
   );

   ram_burst_ptr #(.ADDR_SIZE(ADDR_SIZE), .MEM_DEPTH(MEM_DEPTH)) u_rd (
      .clk     (clk),
      .rst     (rst),
      .load    (rd_load),
      .inc     (rd_inc),
      .addr    (addr),
      .ptr     (rd_ptr),
      .illegal (rd_ill)
   );

   // Pointers never exceed MEM_DEPTH-1, so the low bits index safely.
   always_ff @(posedge clk) begin
      if (!rst && wr_data)
         mem[wr_ptr[IDX_W-1:0]] <= payload;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dout     <= '0;
         tx_valid <= 1'b0;
         err      <= 1'b0;
      end else begin
         tx_valid <= rd_data;
         if (rd_data)
            dout <= mem[rd_ptr[IDX_W-1:0]];
         if (wr_ill || rd_ill)
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_ram_burst.sv
// Scoreboard bench for ram_burst (DATA_WIDTH=8, ADDR_SIZE=8, MEM_DEPTH=200).
// Expected reads queue up at issue; a monitor pops them on each tx_valid.
module tb_ram_burst;
   import ram_burst_pkg::*;

   localparam int DW = 8;
   localparam int AW = 8;
   localparam int MD = 200;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic              clk_tb = 1'b0;
   logic              rst;
   logic [DW+1:0]     din;
   logic              rx_valid;
   logic [DW-1:0]     dout;
   logic              tx_valid;
   logic              err;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t q[$];

   ram_burst #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .MEM_DEPTH(MD)) dut (
      .clk      (clk_tb),
      .rst      (rst),
      .din      (din),
      .rx_valid (rx_valid),
      .dout     (dout),
      .tx_valid (tx_valid),
      .err      (err)
   );

   always #5 clk_tb = ~clk_tb;

   always @(posedge clk_tb) cyc <= cyc + 1;

   // Monitor: every tx_valid must match the oldest queued read, on time.
   always @(negedge clk_tb) begin
      if (tx_valid) begin
         total++;
         if (q.size() == 0) begin
            bad++;
            $display("FAIL spurious_tx cyc=%0d dout=%h expected no tx", cyc, dout);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (dout !== e.data || cyc != e.cyc) begin
               bad++;
               $display("FAIL read got=%h@%0d expected=%h@%0d",
                        dout, cyc, e.data, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic send(input cmd_e c, input logic [DW-1:0] p);
      @(negedge clk_tb);
      din      = {c, p};
      rx_valid = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk_tb);
         rx_valid = 1'b0;
         din      = '0;
      end
   endtask

   task automatic rd(input logic [DW-1:0] e);
      exp_t x;
      send(CMD_RD_DATA, 8'h00);
      x.data = e;
      x.cyc  = cyc + 1;
      q.push_back(x);
   endtask

   initial begin
      rst      = 1'b1;
      rx_valid = 1'b0;
      din      = '0;
      repeat (2) @(posedge clk_tb);
      @(negedge clk_tb);
      rst = 1'b0;
      idle(2);
      chk("reset_dout", dout, 8'h00);
      chk("reset_tx", {7'd0, tx_valid}, 8'h00);
      chk("reset_err", {7'd0, err}, 8'h00);

      // basic write/read
      send(CMD_WR_ADDR, 8'h10);
      send(CMD_WR_DATA, 8'hA5);
      send(CMD_RD_ADDR, 8'h10);
      rd(8'hA5);
      idle(3);
      chk("basic_err", {7'd0, err}, 8'h00);

      // burst near the top of memory
      send(CMD_WR_ADDR, 8'(MD - 2));
      send(CMD_WR_DATA, 8'h11);
      send(CMD_WR_DATA, 8'h22);
      send(CMD_WR_DATA, 8'h33);
      send(CMD_RD_ADDR, 8'(MD - 2));
`ifdef RAM_BURST_AUTO_INC_EN
      rd(8'h11);
      rd(8'h22);
      rd(8'h33);
      send(CMD_RD_ADDR, 8'h00);
      rd(8'h33);
`else
      rd(8'h33);
      rd(8'h33);
      rd(8'h33);
`endif
      idle(1);
      chk("burst_err", {7'd0, err}, 8'h00);
      idle(2);

      // out-of-range read address
      send(CMD_WR_ADDR, 8'h05);
      send(CMD_WR_DATA, 8'h3C);
      send(CMD_RD_ADDR, 8'h05);
      send(CMD_RD_ADDR, 8'd200);
      rd(8'h3C);
      idle(1);
      chk("oor_err_set", {7'd0, err}, 8'h01);
      idle(3);
      chk("oor_err_sticky", {7'd0, err}, 8'h01);

      // reset in the same cycle as a read command
      send(CMD_WR_ADDR, 8'h00);
      send(CMD_WR_DATA, 8'h5A);
      send(CMD_WR_ADDR, 8'h07);
      send(CMD_RD_ADDR, 8'h05);
      @(negedge clk_tb);
      din      = {CMD_RD_DATA, 8'h00};
      rx_valid = 1'b1;
      rst      = 1'b1;
      @(negedge clk_tb);
      rst      = 1'b0;
      rx_valid = 1'b0;
      chk("rst_mid_tx", {7'd0, tx_valid}, 8'h00);
      chk("rst_mid_dout", dout, 8'h00);
      chk("rst_mid_err", {7'd0, err}, 8'h00);
      rd(8'h5A);
      send(CMD_WR_DATA, 8'h77);
      send(CMD_RD_ADDR, 8'h00);
      rd(8'h77);
      idle(3);
      chk("dout_hold", dout, 8'h77);

      // last legal address, then an illegal write address
      send(CMD_WR_ADDR, 8'(MD - 1));
      send(CMD_WR_DATA, 8'hC7);
      idle(1);
      chk("edge_addr_err", {7'd0, err}, 8'h00);
      send(CMD_WR_ADDR, 8'hFF);
      idle(1);
      chk("wr_oor_err", {7'd0, err}, 8'h01);
      send(CMD_WR_DATA, 8'hEE);
      send(CMD_RD_ADDR, 8'(MD - 1));
`ifdef RAM_BURST_AUTO_INC_EN
      rd(8'hC7);
`else
      rd(8'hEE);
`endif
      idle(5);

      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain pending=%0d expected=0", q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_burst.md
Name: ram_burst

Overview:
- Parametrised successor to the command-driven single-port RAM behind the SPI slave.
- Accepts 2-bit-tagged command words on din/rx_valid and returns read data on dout/tx_valid.
- Generalised in data width, address width and depth (including non-power-of-2 depths).
- Adds independent read/write pointers with optional burst auto-increment, plus a sticky error flag for illegal addresses.

Parameters:
- DATA_WIDTH, 8, width of a memory word and of dout.
- ADDR_SIZE, 8, address field width. Must satisfy ADDR_SIZE <= DATA_WIDTH.
- MEM_DEPTH, 256, number of words. Must satisfy MEM_DEPTH <= 2**ADDR_SIZE.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DATA_WIDTH+2  din[DATA_WIDTH+1:DATA_WIDTH] = command, din[DATA_WIDTH-1:0] = payload.
- rx_valid  in  1  din is a valid command this cycle.
- dout  out  DATA_WIDTH  read data.
- tx_valid  out  1  dout is valid (one-cycle pulse).
- err  out  1  sticky illegal-address flag.

Behaviour:
- Reset (rst=1 at posedge):
  - dout=0, tx_valid=0, err=0, wr_ptr=0, rd_ptr=0.
  - Memory contents are not reset.
  - rst has priority over rx_valid in the same cycle; the command is dropped.
- Commands are decoded only when rx_valid=1. With rx_valid=0, all state holds and tx_valid=0.
- CMD_WR_ADDR (00): wr_ptr <= din[ADDR_SIZE-1:0].
- CMD_WR_DATA (01): mem[wr_ptr] <= din[DATA_WIDTH-1:0].
- CMD_RD_ADDR (10): rd_ptr <= din[ADDR_SIZE-1:0].
- CMD_RD_DATA (11): payload is ignored. At the next posedge, dout <= mem[rd_ptr] and tx_valid=1 for exactly one cycle.
- Read latency is 1 cycle from the accepting edge. dout holds its last value after tx_valid falls.
- Address range checking:
  - A WR_ADDR or RD_ADDR payload >= MEM_DEPTH sets err=1 and leaves the pointer unchanged.
  - err stays set until rst.
- Back-to-back CMD_RD_DATA commands every cycle produce tx_valid high every cycle.
- Write to rd_ptr followed by CMD_RD_DATA in the next cycle returns the new data (no forwarding needed, since one command is accepted per cycle).
- tx_valid=0 on any non-read command.

Optional Feature:
- Macro: RAM_BURST_AUTO_INC_EN.
- Defined:
  - After each CMD_WR_DATA, wr_ptr increments.
  - After each CMD_RD_DATA, rd_ptr increments.
  - A pointer at MEM_DEPTH-1 wraps to 0. Wrap never sets err.
- Not defined: pointers change only on the *_ADDR commands, matching first-generation behaviour.

Decomposition:
- Shared package ram_burst_pkg contains:
  - typedef enum logic [1:0] cmd_e {CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11}.
  - localparam CMD_W=2.
- Sub-module ram_burst_ptr: pointer register with sync reset, load, increment-with-wrap at MEM_DEPTH-1, and range check that returns an illegal flag. Instantiated twice (wr, rd).
- Memory array and output registers live in the top module.

Test Plan:
- Reset then idle:
  - Hold rst=1 for 2 cycles, then rx_valid=0 -> dout=0, tx_valid=0, err=0.
- Basic write/read (defaults):
  - Commands: WR_ADDR 0x10, WR_DATA 0xA5, RD_ADDR 0x10, RD_DATA.
  - Expect: tx_valid=1 one cycle after RD_DATA with dout=0xA5, then tx_valid=0.
- Burst with RAM_BURST_AUTO_INC_EN:
  - Commands: WR_ADDR 0xFE, WR_DATA 0x11, 0x22, 0x33; RD_ADDR 0xFE; RD_DATA x3.
  - Expect: dout = 0x11, 0x22, 0x33 on consecutive cycles, tx_valid high for 3 cycles, address 0x00 holds 0x33 (wrap), err=0.
- Out-of-range address (MEM_DEPTH=200):
  - Commands: RD_ADDR 0x05, then RD_ADDR 0xC8 (200), then RD_DATA.
  - Expect: err=1 and stays 1; read returns mem[0x05].
- Reset mid-operation:
  - rst=1 in the same cycle as RD_DATA.
  - Expect: tx_valid=0, dout=0, pointers=0; a later RD_DATA reads mem[0].
- Idle gaps: rx_valid=0 between commands for 3 cycles -> no state change, tx_valid=0 throughout.
